// File: rtl/caliptra_fpga_apb_sequencer_pkg.sv
// caliptra_fpga_apb_sequencer_pkg: shared types and constants for the APB sequencer
package caliptra_fpga_sync_pkg;
  localparam int unsigned APB_SEQ_TIMEOUT_DEFAULT = 1024;
  localparam int unsigned APB_SEQ_AW = 32;
  localparam int unsigned APB_SEQ_DW = 32;
  localparam int unsigned APB_SEQ_UW = 32;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_seq_state_e;
  typedef struct packed {
    logic                  write;
    logic [APB_SEQ_AW-1:0] addr;
    logic [APB_SEQ_DW-1:0] wdata;
    logic [2:0]            pprot;
    logic [APB_SEQ_UW-1:0] pauser;
  } apb_seq_req_t;
  typedef struct packed {
    logic [APB_SEQ_DW-1:0] rdata;
    logic                  slverr;
    logic                  timeout;
  } apb_seq_rsp_t;
endpackage

// File: rtl/caliptra_fpga_apb_sequencer_if.sv
// caliptra_fpga_apb_sequencer_if: request/response handshake plus APB3 bus of the sequencer
interface caliptra_fpga_apb_sequencer_if #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned PAUSER_WIDTH = 32
);
  logic                    req_valid, req_ready, req_write;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [2:0]              req_pprot;
  logic [PAUSER_WIDTH-1:0] req_pauser;
  logic                    rsp_valid, rsp_ack, rsp_slverr, rsp_timeout;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA, PRDATA;
  logic [2:0]              PPROT;
  logic [PAUSER_WIDTH-1:0] PAUSER;
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_pprot, req_pauser, rsp_ack,
           PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA, PPROT, PAUSER
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_pprot, req_pauser, rsp_ack,
           PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA, PPROT, PAUSER
  );
endinterface

// File: rtl/caliptra_fpga_apb_sequencer_wdog.sv
// caliptra_fpga_apb_wdog: counts stalled ACCESS cycles and flags when the limit is reached
module caliptra_fpga_apb_wdog
  import caliptra_fpga_sync_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = APB_SEQ_TIMEOUT_DEFAULT
) (
  input  logic aclk_gated,
  input  logic rstn,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int unsigned W = $clog2(TIMEOUT_CYCLES);
  logic [W-1:0] cnt_q, cnt_d;
  // clear wins over count so every ACCESS phase starts from zero
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
  // counter register, frozen whenever the gated clock stops
  always_ff @(posedge aclk_gated or negedge rstn)
    if (!rstn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired_o = cnt_q == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/caliptra_fpga_apb_sequencer.sv
// caliptra_fpga_apb_sequencer: turns one queued request into one APB3 transfer; watchdog under CALIPTRA_FPGA_APB_TIMEOUT_EN
module caliptra_fpga_apb_sequencer
  import caliptra_fpga_sync_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = APB_SEQ_AW,
  parameter int unsigned DATA_WIDTH     = APB_SEQ_DW,
  parameter int unsigned PAUSER_WIDTH   = APB_SEQ_UW,
  parameter int unsigned TIMEOUT_CYCLES = APB_SEQ_TIMEOUT_DEFAULT
) (
  input logic                          aclk_gated,
  input logic                          rstn,
  caliptra_fpga_apb_sequencer_if.master apb_seq
);
  apb_seq_state_e state_q, state_d;
  apb_seq_req_t   req_q, req_d;
  apb_seq_rsp_t   rsp_q, rsp_d;
  logic           expired;
`ifdef CALIPTRA_FPGA_APB_TIMEOUT_EN
  caliptra_fpga_apb_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .aclk_gated(aclk_gated),
    .rstn      (rstn),
    .clr_i     (state_q == SETUP),
    .en_i      (state_q == ACCESS && !apb_seq.PREADY),
    .expired_o (expired)
  );
`else
  assign expired = 1'b0;
`endif
  // state, captured request and captured response; reset drops PSEL/PENABLE at once
  always_ff @(posedge aclk_gated or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      req_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
    end
  // next state plus request capture on acceptance and response capture on completion
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    case (state_q)
      IDLE: if (apb_seq.req_valid) begin
        state_d = SETUP;
        req_d   = '{write: apb_seq.req_write, addr: APB_SEQ_AW'(apb_seq.req_addr),
                    wdata: APB_SEQ_DW'(apb_seq.req_wdata), pprot: apb_seq.req_pprot,
                    pauser: APB_SEQ_UW'(apb_seq.req_pauser)};
      end
      SETUP: state_d = ACCESS;
      ACCESS: if (apb_seq.PREADY) begin
        state_d = RESP;
        rsp_d   = '{rdata: req_q.write ? '0 : APB_SEQ_DW'(apb_seq.PRDATA),
                    slverr: apb_seq.PSLVERR, timeout: 1'b0};
      end else if (expired) begin
        state_d = RESP;
        rsp_d   = '{rdata: '0, slverr: 1'b1, timeout: 1'b1};
      end
      RESP: if (apb_seq.rsp_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // bus and handshake outputs decoded from state and captured registers
  always_comb begin
    apb_seq.req_ready   = state_q == IDLE;
    apb_seq.rsp_valid   = state_q == RESP;
    apb_seq.PSEL        = state_q == SETUP || state_q == ACCESS;
    apb_seq.PENABLE     = state_q == ACCESS;
    apb_seq.PWRITE      = req_q.write;
    apb_seq.PADDR       = req_q.addr[ADDR_WIDTH-1:0];
    apb_seq.PWDATA      = req_q.wdata[DATA_WIDTH-1:0];
    apb_seq.PPROT       = req_q.pprot;
    apb_seq.PAUSER      = req_q.pauser[PAUSER_WIDTH-1:0];
    apb_seq.rsp_rdata   = rsp_q.rdata[DATA_WIDTH-1:0];
    apb_seq.rsp_slverr  = rsp_q.slverr;
    apb_seq.rsp_timeout = rsp_q.timeout;
  end
endmodule

// File: tb/tb_caliptra_fpga_apb_sequencer.sv
// tb_caliptra_fpga_apb_sequencer: directed checks of the APB sequencer
module tb_caliptra_fpga_apb_sequencer;
  logic clk, gate, aclk_gated, rstn;
  int   n_cmp, n_err;
  caliptra_fpga_apb_sequencer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PAUSER_WIDTH(32)) bus ();
  caliptra_fpga_apb_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .aclk_gated(aclk_gated),
    .rstn      (rstn),
    .apb_seq   (bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign aclk_gated = clk & gate;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    bus.req_pprot  = 3'b010;
    bus.req_pauser = 32'h0000_00AB;
    step();
    bus.req_valid  = 1'b0;
  endtask
  task automatic ack();
    bus.rsp_ack = 1'b1;
    step();
    bus.rsp_ack = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
  initial begin
    n_cmp = 0;
    n_err = 0;
    gate = 1'b1;
    rstn = 1'b0;
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus.req_pprot = 0; bus.req_pauser = 0; bus.rsp_ack = 0;
    bus.PRDATA = 0; bus.PREADY = 0; bus.PSLVERR = 0;
    repeat (3) step();
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_psel", bus.PSEL, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_paddr", bus.PADDR, 0);
    rstn = 1'b1;
    step();
    // write, PREADY high immediately, PRDATA garbage must not leak into rdata
    bus.PREADY = 1; bus.PRDATA = 32'hDEAD_BEEF;
    issue(1, 32'h3002_0000, 32'hA5A5_5A5A);
    chk("wr_setup_psel", bus.PSEL, 1);
    chk("wr_setup_penable", bus.PENABLE, 0);
    chk("wr_setup_ready", bus.req_ready, 0);
    chk("wr_paddr", bus.PADDR, 32'h3002_0000);
    chk("wr_pwdata", bus.PWDATA, 32'hA5A5_5A5A);
    chk("wr_pwrite", bus.PWRITE, 1);
    chk("wr_pprot", bus.PPROT, 3'b010);
    chk("wr_pauser", bus.PAUSER, 32'hAB);
    step();
    chk("wr_access_psel", bus.PSEL, 1);
    chk("wr_access_penable", bus.PENABLE, 1);
    chk("wr_access_rsp", bus.rsp_valid, 0);
    step();
    chk("wr_resp_valid", bus.rsp_valid, 1);
    chk("wr_resp_psel", bus.PSEL, 0);
    chk("wr_resp_rdata", bus.rsp_rdata, 0);
    chk("wr_resp_slverr", bus.rsp_slverr, 0);
    ack();
    chk("wr_idle_valid", bus.rsp_valid, 0);
    chk("wr_idle_ready", bus.req_ready, 1);
    // ack outside RESP is ignored
    ack();
    chk("stray_ack_ready", bus.req_ready, 1);
    chk("stray_ack_psel", bus.PSEL, 0);
    // read with five wait states
    bus.PREADY = 0; bus.PRDATA = 32'h1234_5678;
    issue(0, 32'h3002_0010, 32'h0);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rd_wait_penable", bus.PENABLE, 1);
      chk("rd_wait_paddr", bus.PADDR, 32'h3002_0010);
      chk("rd_wait_pwrite", bus.PWRITE, 0);
      chk("rd_wait_rsp", bus.rsp_valid, 0);
    end
    bus.PREADY = 1;
    step();
    chk("rd_resp_valid", bus.rsp_valid, 1);
    chk("rd_resp_rdata", bus.rsp_rdata, 32'h1234_5678);
    bus.PRDATA = 32'hCAFE_F00D; bus.PSLVERR = 1;
    bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 32'h3002_0020;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rd_hold_valid", bus.rsp_valid, 1);
      chk("rd_hold_rdata", bus.rsp_rdata, 32'h1234_5678);
      chk("rd_hold_ready", bus.req_ready, 0);
      chk("rd_hold_psel", bus.PSEL, 0);
    end
    ack();
    chk("gap_ready", bus.req_ready, 1);
    chk("gap_psel", bus.PSEL, 0);
    step();
    bus.req_valid = 0;
    chk("b2b_setup_psel", bus.PSEL, 1);
    chk("b2b_paddr", bus.PADDR, 32'h3002_0020);
    step();
    step();
    chk("err_resp_valid", bus.rsp_valid, 1);
    chk("err_slverr", bus.rsp_slverr, 1);
    chk("err_timeout", bus.rsp_timeout, 0);
    chk("err_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
    ack();
    bus.PSLVERR = 0;
`ifdef CALIPTRA_FPGA_APB_TIMEOUT_EN
    // PREADY stuck low: abort on the 16th ACCESS cycle
    bus.PREADY = 0; bus.PRDATA = 32'h5555_AAAA;
    issue(0, 32'h3002_0030, 32'h0);
    step();
    for (int i = 0; i < 15; i++) begin
      step();
      chk("to_wait_penable", bus.PENABLE, 1);
    end
    step();
    chk("to_resp_valid", bus.rsp_valid, 1);
    chk("to_timeout", bus.rsp_timeout, 1);
    chk("to_slverr", bus.rsp_slverr, 1);
    chk("to_rdata", bus.rsp_rdata, 0);
    ack();
    // PREADY rising on the limit edge wins
    issue(0, 32'h3002_0030, 32'h0);
    step();
    for (int i = 0; i < 15; i++) step();
    chk("lim_still_access", bus.PENABLE, 1);
    bus.PREADY = 1;
    step();
    chk("lim_resp_valid", bus.rsp_valid, 1);
    chk("lim_timeout", bus.rsp_timeout, 0);
    chk("lim_slverr", bus.rsp_slverr, 0);
    chk("lim_rdata", bus.rsp_rdata, 32'h5555_AAAA);
    ack();
`endif
    // gated clock during ACCESS freezes everything
    bus.PREADY = 0; bus.PRDATA = 32'h0F0F_1234;
    issue(0, 32'h3002_0040, 32'h0);
    step();
    repeat (3) step();
    @(negedge clk) gate = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("gate_psel", bus.PSEL, 1);
    chk("gate_penable", bus.PENABLE, 1);
    chk("gate_rsp", bus.rsp_valid, 0);
    @(negedge clk) gate = 1'b1;
    repeat (10) step();
    chk("gate_resume_access", bus.PENABLE, 1);
    bus.PREADY = 1;
    step();
    chk("gate_resp_valid", bus.rsp_valid, 1);
    chk("gate_timeout", bus.rsp_timeout, 0);
    chk("gate_rdata", bus.rsp_rdata, 32'h0F0F_1234);
    ack();
    // reset asserted mid-ACCESS
    bus.PREADY = 0;
    issue(0, 32'h3002_0050, 32'h0);
    step();
    chk("rstmid_access", bus.PENABLE, 1);
    #2 rstn = 1'b0;
    #1;
    chk("rstmid_psel", bus.PSEL, 0);
    chk("rstmid_penable", bus.PENABLE, 0);
    chk("rstmid_rsp", bus.rsp_valid, 0);
    step();
    rstn = 1'b1;
    step();
    chk("rstrel_ready", bus.req_ready, 1);
    chk("rstrel_rdata", bus.rsp_rdata, 0);
    bus.PREADY = 1; bus.PRDATA = 32'h0BAD_F00D;
    issue(0, 32'h3002_0060, 32'h0);
    step();
    step();
    chk("post_rst_valid", bus.rsp_valid, 1);
    chk("post_rst_rdata", bus.rsp_rdata, 32'h0BAD_F00D);
    chk("post_rst_slverr", bus.rsp_slverr, 0);
    ack();
    chk("post_rst_idle", bus.req_ready, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
